toast_lsu: RTL and testbench

//  Load/store unit: parametrised successor of the MEM stage, between EX and WB.

---
 rtl/toast_def_pkg.sv | 45 ++++
 rtl/toast_lsu_align.sv | 56 +++++
 rtl/toast_lsu.sv | 180 ++++++++++++++++++
 tb/tb_toast_lsu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/toast_def_pkg.sv
// Shared definitions for the toast pipeline: memory op codes, LSU state
// encoding and per-op helper functions.
package toast_def_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_REQ0 = 3'd1,
        LSU_RSP0 = 3'd2,
        LSU_REQ1 = 3'd3,
        LSU_RSP1 = 3'd4
    } lsu_state_t;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;
    localparam logic [3:0] MEM_LD   = 4'd9;
    localparam logic [3:0] MEM_SD   = 4'd10;
    localparam logic [3:0] MEM_LW_U = 4'd11;

    // Access size in bytes; 0 for MEM_NONE and unassigned codes.
    function automatic logic [3:0] mem_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB:   mem_size = 4'd1;
            MEM_LH, MEM_LHU, MEM_SH:   mem_size = 4'd2;
            MEM_LW, MEM_LW_U, MEM_SW:  mem_size = 4'd4;
            MEM_LD, MEM_SD:            mem_size = 4'd8;
            default:                   mem_size = 4'd0;
        endcase
    endfunction

    function automatic logic mem_is_store(input logic [3:0] op);
        mem_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    function automatic logic mem_is_signed(input logic [3:0] op);
        mem_is_signed = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    endfunction

endpackage

// File: rtl/toast_lsu_align.sv
// Lane alignment for the LSU: store data/byte-enable shifting across two
// beats and load data merge with sign/zero extension. Purely combinational.
module toast_lsu_align
    import toast_def_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8,
    parameter int OFF_W  = $clog2(BE_W)
) (
    input  logic [3:0]        op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_lo,
    input  logic [DATA_W-1:0] rdata_hi,
    output logic [BE_W-1:0]   be0,
    output logic [BE_W-1:0]   be1,
    output logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] ld_data
);

    localparam int BE2_W = 2 * BE_W;

    logic [2*DATA_W-1:0]      wide;
    logic [BE2_W-1:0]         smask;
    logic [BE2_W-1:0]         be2;
    logic [DATA_W-1:0]        merged;
    logic signed [DATA_W-1:0] tmp;
    logic signed [DATA_W-1:0] sx;
    logic [DATA_W-1:0]        zx;
    int                       sh;
    int                       esh;

    // Store path: shift data and size mask into a double-width window, split in halves.
    always_comb begin
        wide   = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
        smask  = BE2_W'((32'd1 << mem_size(op)) - 32'd1);
        be2    = smask << off;
        be0    = be2[BE_W-1:0];
        be1    = be2[BE2_W-1:BE_W];
        wdata0 = wide[DATA_W-1:0];
        wdata1 = wide[2*DATA_W-1:DATA_W];
    end

    // Load path: {hi,lo} >> 8*off keeping the low word, then extend to op size.
    always_comb begin
        sh     = 8 * int'(off);
        merged = (rdata_lo >> sh) | ((sh == 0) ? '0 : (rdata_hi << (DATA_W - sh)));
        esh    = (8 * int'(mem_size(op)) >= DATA_W) ? 0 : DATA_W - 8 * int'(mem_size(op));
        tmp    = merged << esh;
        sx     = tmp >>> esh;
        zx     = (merged << esh) >> esh;
        ld_data = mem_is_signed(op) ? sx : zx;
    end

endmodule

// File: rtl/toast_lsu.sv
// Load/store unit between EX and WB. One op outstanding; lane-crossing
// accesses go out as two aligned beats (or trap when splitting is disabled).
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  LSU_IDLE | ready for EX; no-bus ops complete straight from here
//  LSU_REQ0 | first beat requested, waiting for gnt
//  LSU_RSP0 | first beat granted, waiting for rvalid
//  LSU_REQ1 | second beat of a split access requested
//  LSU_RSP1 | second beat granted, waiting for rvalid
module toast_lsu
    import toast_def_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int SPLIT_MISALGN = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [3:0]          ex_mem_op_i,
    input  logic [ADDR_W-1:0]   ex_addr_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic [4:0]          ex_rd_addr_i,
    input  logic                ex_rd_wr_en_i,
    input  logic                ex_exception_i,
    output logic                dmem_req_o,
    input  logic                dmem_gnt_i,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [DATA_W/8-1:0] dmem_be_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    input  logic                dmem_rvalid_i,
    input  logic [DATA_W-1:0]   dmem_rdata_i,
    input  logic                dmem_err_i,
    output logic                lsu_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_memtoreg_o,
    output logic [4:0]          lsu_rd_addr_o,
    output logic                lsu_rd_wr_en_o,
    output logic                lsu_exception_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    lsu_state_t        state, state_nxt;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [4:0]        rd_q;
    logic              wren_q;

    logic [3:0]        ex_size;
    logic              ex_mis, ex_ill, ex_exc_now, ex_bus, accept;
    logic              done, cap_lo, split;
    logic [BE_W-1:0]   be0, be1;
    logic [DATA_W-1:0] wdata0, wdata1, ld_lo, ld_hi, ld_data;

    // Classify the incoming op: 64-bit ops on a 32-bit bus and unknown codes are illegal.
    always_comb begin
        ex_size    = mem_size(ex_mem_op_i);
        ex_mis     = (int'(ex_addr_i[OFF_W-1:0]) + int'(ex_size)) > BE_W;
        ex_ill     = (ex_mem_op_i != MEM_NONE) && ((ex_size == 4'd0) || (int'(ex_size) > BE_W));
        ex_exc_now = ex_exception_i || ex_ill ||
                     ((ex_mem_op_i != MEM_NONE) && ex_mis && (SPLIT_MISALGN == 0));
        ex_bus     = (ex_mem_op_i != MEM_NONE) && !ex_exc_now;
        accept     = ex_valid_i && ex_ready_o;
    end

    toast_lsu_align #(.DATA_W(DATA_W)) u_align (
        .op       (op_q),
        .off      (addr_q[OFF_W-1:0]),
        .wdata    (wdata_q),
        .rdata_lo (ld_lo),
        .rdata_hi (ld_hi),
        .be0      (be0),
        .be1      (be1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ld_data  (ld_data)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= LSU_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and beat sequencing.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        cap_lo    = 1'b0;
        case (state)
            LSU_IDLE: if (accept && ex_bus) state_nxt = LSU_REQ0;
            LSU_REQ0: if (dmem_gnt_i) state_nxt = LSU_RSP0;
            LSU_RSP0: begin
                if (dmem_rvalid_i) begin
                    if (dmem_err_i || !split) begin
                        done      = 1'b1;
                        state_nxt = LSU_IDLE;
                    end else begin
                        cap_lo    = 1'b1;
                        state_nxt = LSU_REQ1;
                    end
                end
            end
            LSU_REQ1: if (dmem_gnt_i) state_nxt = LSU_RSP1;
            LSU_RSP1: begin
                if (dmem_rvalid_i) begin
                    done      = 1'b1;
                    state_nxt = LSU_IDLE;
                end
            end
            default:  state_nxt = LSU_IDLE;
        endcase
    end

    // Bus outputs derive only from registered state, so they hold while req waits for gnt.
    always_comb begin
        split        = |be1;
        ex_ready_o   = (state == LSU_IDLE);
        dmem_req_o   = (state == LSU_REQ0) || (state == LSU_REQ1);
        dmem_we_o    = mem_is_store(op_q);
        dmem_addr_o  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} +
                       ((state == LSU_REQ1) ? ADDR_W'(BE_W) : '0);
        dmem_be_o    = (state == LSU_REQ1) ? be1 : be0;
        dmem_wdata_o = (state == LSU_REQ1) ? wdata1 : wdata0;
        ld_lo        = (state == LSU_RSP1) ? rdata0_q : dmem_rdata_i;
        ld_hi        = (state == LSU_RSP1) ? dmem_rdata_i : '0;
    end

    // Op capture and result registers; lsu_valid_o is a single-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q            <= MEM_NONE;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata0_q        <= '0;
            rd_q            <= '0;
            wren_q          <= 1'b0;
            lsu_valid_o     <= 1'b0;
            lsu_rdata_o     <= '0;
            lsu_memtoreg_o  <= 1'b0;
            lsu_rd_addr_o   <= '0;
            lsu_rd_wr_en_o  <= 1'b0;
            lsu_exception_o <= 1'b0;
        end else begin
            lsu_valid_o <= 1'b0;
            if (accept) begin
                op_q    <= ex_mem_op_i;
                addr_q  <= ex_addr_i;
                wdata_q <= ex_wdata_i;
                rd_q    <= ex_rd_addr_i;
                wren_q  <= ex_rd_wr_en_i;
                if (!ex_bus) begin
                    lsu_valid_o     <= 1'b1;
                    lsu_rdata_o     <= DATA_W'(ex_addr_i);
                    lsu_memtoreg_o  <= 1'b0;
                    lsu_rd_addr_o   <= ex_rd_addr_i;
                    lsu_rd_wr_en_o  <= ex_rd_wr_en_i && !ex_exc_now;
                    lsu_exception_o <= ex_exc_now;
                end
            end
            if (cap_lo) rdata0_q <= dmem_rdata_i;
            if (done) begin
                lsu_valid_o     <= 1'b1;
                lsu_rdata_o     <= mem_is_store(op_q) ? DATA_W'(addr_q) : ld_data;
                lsu_memtoreg_o  <= !mem_is_store(op_q) && !dmem_err_i;
                lsu_rd_addr_o   <= rd_q;
                lsu_rd_wr_en_o  <= wren_q && !dmem_err_i;
                lsu_exception_o <= dmem_err_i;
            end
        end
    end

endmodule

// File: tb/tb_toast_lsu.sv
// Directed bench for toast_lsu: a splitting instance drives the bus checks,
// a trap-mode instance sees the same EX stimulus for the misaligned-trap case.
module tb_toast_lsu;
    import toast_def_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid, ex_rd_wr_en, ex_exception;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd_addr;
    logic        dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_rdata;

    logic        ex_ready, dmem_req, dmem_we, lsu_valid, lsu_memtoreg, lsu_rd_wr_en, lsu_exception;
    logic [31:0] dmem_addr, dmem_wdata, lsu_rdata;
    logic [3:0]  dmem_be;
    logic [4:0]  lsu_rd_addr;

    logic        t_ready, t_req, t_we, t_valid, t_memtoreg, t_rd_wr_en, t_exception;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [3:0]  t_be;
    logic [4:0]  t_rd_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    toast_lsu #(.ADDR_W(32), .DATA_W(32), .SPLIT_MISALGN(1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_mem_op_i(ex_mem_op),
        .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_addr_i(ex_rd_addr),
        .ex_rd_wr_en_i(ex_rd_wr_en), .ex_exception_i(ex_exception),
        .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
        .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err),
        .lsu_valid_o(lsu_valid), .lsu_rdata_o(lsu_rdata), .lsu_memtoreg_o(lsu_memtoreg),
        .lsu_rd_addr_o(lsu_rd_addr), .lsu_rd_wr_en_o(lsu_rd_wr_en), .lsu_exception_o(lsu_exception)
    );

    toast_lsu #(.ADDR_W(32), .DATA_W(32), .SPLIT_MISALGN(0)) u_trap (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid), .ex_ready_o(t_ready), .ex_mem_op_i(ex_mem_op),
        .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_addr_i(ex_rd_addr),
        .ex_rd_wr_en_i(ex_rd_wr_en), .ex_exception_i(ex_exception),
        .dmem_req_o(t_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(t_we),
        .dmem_addr_o(t_addr), .dmem_be_o(t_be), .dmem_wdata_o(t_wdata),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err),
        .lsu_valid_o(t_valid), .lsu_rdata_o(t_rdata), .lsu_memtoreg_o(t_memtoreg),
        .lsu_rd_addr_o(t_rd_addr), .lsu_rd_wr_en_o(t_rd_wr_en), .lsu_exception_o(t_exception)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one op for a single cycle; the LSU must be ready to take it.
    task automatic accept(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic wren, input logic exc, input string tag);
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wdata = wdata;
        ex_rd_addr = rd; ex_rd_wr_en = wren; ex_exception = exc;
        chk({tag, "_ready"}, 64'(ex_ready), 64'd1);
        tick();
        ex_valid = 1'b0;
    endtask

    // Serve one bus beat: hold gnt low for gnt_wait cycles, grant, answer one cycle later.
    task automatic bus_beat(input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic exp_we,
                            input logic [31:0] exp_wdata, input int gnt_wait,
                            input logic [31:0] rdata, input logic err, input string tag);
        for (int i = 0; i < gnt_wait; i++) begin
            chk({tag, "_stall_req"},   64'(dmem_req),  64'd1);
            chk({tag, "_stall_addr"},  64'(dmem_addr), 64'(exp_addr));
            chk({tag, "_stall_be"},    64'(dmem_be),   64'(exp_be));
            chk({tag, "_stall_ready"}, 64'(ex_ready),  64'd0);
            tick();
        end
        chk({tag, "_req"},  64'(dmem_req),  64'd1);
        chk({tag, "_addr"}, 64'(dmem_addr), 64'(exp_addr));
        chk({tag, "_be"},   64'(dmem_be),   64'(exp_be));
        chk({tag, "_we"},   64'(dmem_we),   64'(exp_we));
        if (exp_we) chk({tag, "_wdata"}, 64'(dmem_wdata), 64'(exp_wdata));
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk({tag, "_rsp_req"},   64'(dmem_req),  64'd0);
        chk({tag, "_rsp_valid"}, 64'(lsu_valid), 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_err = err;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
    endtask

    // Check the result pulse in the current cycle and that it lasts one cycle.
    task automatic result(input logic [31:0] exp_rdata, input logic check_rdata, input logic exp_m2r,
                          input logic [4:0] exp_rd, input logic exp_wren, input logic exp_exc,
                          input string tag);
        chk({tag, "_valid"}, 64'(lsu_valid), 64'd1);
        if (check_rdata) chk({tag, "_rdata"}, 64'(lsu_rdata), 64'(exp_rdata));
        chk({tag, "_memtoreg"}, 64'(lsu_memtoreg),  64'(exp_m2r));
        chk({tag, "_rd"},       64'(lsu_rd_addr),   64'(exp_rd));
        chk({tag, "_wren"},     64'(lsu_rd_wr_en),  64'(exp_wren));
        chk({tag, "_exc"},      64'(lsu_exception), 64'(exp_exc));
        chk({tag, "_req_idle"}, 64'(dmem_req),      64'd0);
        tick();
        chk({tag, "_pulse_end"}, 64'(lsu_valid), 64'd0);
        chk({tag, "_req_after"}, 64'(dmem_req),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        ex_valid = 1'b0; ex_mem_op = MEM_NONE; ex_addr = '0; ex_wdata = '0;
        ex_rd_addr = '0; ex_rd_wr_en = 1'b0; ex_exception = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
        repeat (3) tick();
        rst_i = 1'b0;

        chk("rst_ready",    64'(ex_ready),      64'd1);
        chk("rst_req",      64'(dmem_req),      64'd0);
        chk("rst_valid",    64'(lsu_valid),     64'd0);
        chk("rst_rdata",    64'(lsu_rdata),     64'd0);
        chk("rst_memtoreg", 64'(lsu_memtoreg),  64'd0);
        chk("rst_rd",       64'(lsu_rd_addr),   64'd0);
        chk("rst_wren",     64'(lsu_rd_wr_en),  64'd0);
        chk("rst_exc",      64'(lsu_exception), 64'd0);

        // SW aligned: single beat, result three cycles after accept.
        accept(MEM_SW, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, "sw");
        bus_beat(32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0, "sw_b0");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sw");

        // LH / LHU from the upper half of a word.
        accept(MEM_LH, 32'h102, 32'h0, 5'd5, 1'b1, 1'b0, "lh");
        bus_beat(32'h100, 4'b1100, 1'b0, 32'h0, 0, 32'h8001_0000, 1'b0, "lh_b0");
        result(32'hFFFF_8001, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, "lh");
        accept(MEM_LHU, 32'h102, 32'h0, 5'd6, 1'b1, 1'b0, "lhu");
        bus_beat(32'h100, 4'b1100, 1'b0, 32'h0, 0, 32'h8001_0000, 1'b0, "lhu_b0");
        result(32'h0000_8001, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, "lhu");

        // Byte accesses and an in-word halfword store.
        accept(MEM_LB, 32'h101, 32'h0, 5'd7, 1'b1, 1'b0, "lb");
        bus_beat(32'h100, 4'b0010, 1'b0, 32'h0, 0, 32'h0000_F000, 1'b0, "lb_b0");
        result(32'hFFFF_FFF0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, "lb");
        accept(MEM_LBU, 32'h103, 32'h0, 5'd8, 1'b1, 1'b0, "lbu");
        bus_beat(32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h7F00_0000, 1'b0, "lbu_b0");
        result(32'h0000_007F, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, "lbu");
        accept(MEM_SB, 32'h102, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, "sb");
        bus_beat(32'h100, 4'b0100, 1'b1, 32'h00AB_0000, 0, 32'h0, 1'b0, "sb_b0");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sb");
        accept(MEM_SH, 32'h106, 32'h0000_1234, 5'd0, 1'b0, 1'b0, "sh");
        bus_beat(32'h104, 4'b1100, 1'b1, 32'h1234_0000, 0, 32'h0, 1'b0, "sh_b0");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sh");

        // Split stores: word at offset 3 and halfword at offset 3.
        accept(MEM_SW, 32'h103, 32'h1122_3344, 5'd0, 1'b0, 1'b0, "sw_split");
        bus_beat(32'h100, 4'b1000, 1'b1, 32'h4400_0000, 0, 32'h0, 1'b0, "sw_split_b0");
        bus_beat(32'h104, 4'b0111, 1'b1, 32'h0011_2233, 0, 32'h0, 1'b0, "sw_split_b1");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sw_split");
        accept(MEM_SH, 32'h107, 32'h0000_1234, 5'd0, 1'b0, 1'b0, "sh_split");
        bus_beat(32'h104, 4'b1000, 1'b1, 32'h3400_0000, 0, 32'h0, 1'b0, "sh_split_b0");
        bus_beat(32'h108, 4'b0001, 1'b1, 32'h0000_0012, 0, 32'h0, 1'b0, "sh_split_b1");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sh_split");

        // Split load; the trap-mode instance must flag it next cycle without a request.
        accept(MEM_LW, 32'h0FE, 32'h0, 5'd3, 1'b1, 1'b0, "lw_split");
        chk("trap_valid", 64'(t_valid),     64'd1);
        chk("trap_exc",   64'(t_exception), 64'd1);
        chk("trap_wren",  64'(t_rd_wr_en),  64'd0);
        chk("trap_req",   64'(t_req),       64'd0);
        bus_beat(32'h0FC, 4'b1100, 1'b0, 32'h0, 0, 32'hAABB_1234, 1'b0, "lw_split_b0");
        chk("trap_req_later", 64'(t_req), 64'd0);
        bus_beat(32'h100, 4'b0011, 1'b0, 32'h0, 0, 32'h5678_CCDD, 1'b0, "lw_split_b1");
        result(32'hCCDD_AABB, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, "lw_split");

        // Grant withheld for five cycles.
        accept(MEM_SW, 32'h200, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, "sw_stall");
        bus_beat(32'h200, 4'b1111, 1'b1, 32'hCAFE_F00D, 5, 32'h0, 1'b0, "sw_stall_b0");
        result(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, "sw_stall");

        // Bus error on the first beat of a split load: no second beat.
        accept(MEM_LW, 32'h0FE, 32'h0, 5'd9, 1'b1, 1'b0, "lw_err");
        bus_beat(32'h0FC, 4'b1100, 1'b0, 32'h0, 0, 32'h0, 1'b1, "lw_err_b0");
        result(32'h0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, "lw_err");

        // Passthrough and upstream exception: result next cycle, no bus traffic.
        accept(MEM_NONE, 32'h1234_5678, 32'h0, 5'd10, 1'b1, 1'b0, "pass");
        result(32'h1234_5678, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, "pass");
        accept(MEM_LW, 32'h400, 32'h0, 5'd11, 1'b1, 1'b1, "upexc");
        result(32'h400, 1'b1, 1'b0, 5'd11, 1'b0, 1'b1, "upexc");

        // Reset while waiting for rvalid: the late response must be dropped.
        accept(MEM_LW, 32'h300, 32'h0, 5'd12, 1'b1, 1'b0, "rst_mid");
        chk("rst_mid_req", 64'(dmem_req), 64'd1);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_req0",   64'(dmem_req),  64'd0);
        chk("rst_mid_ready",  64'(ex_ready),  64'd1);
        chk("rst_mid_valid0", 64'(lsu_valid), 64'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("rst_mid_late_valid", 64'(lsu_valid),    64'd0);
        chk("rst_mid_late_wren",  64'(lsu_rd_wr_en), 64'd0);
        tick();
        chk("rst_mid_valid2", 64'(lsu_valid), 64'd0);
        chk("rst_mid_req2",   64'(dmem_req),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
